mvm_stream_engine: RTL and testbench

//  Parametrised signed fixed-point matrix-vector multiplier: y = A*x, A is M_ROWS x N_COLS, x is N_COLS.

---
 rtl/mvm_stream_engine.sv | 147 ++++++++++++++
 tb/tb_mvm_stream_engine.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mvm_stream_engine.sv
// Column-serial signed matrix-vector multiplier, y = A*x.
// M_ROWS parallel MACs consume one column of A per cycle; operands are taken together in one
// handshake, the result is presented on a registered valid/ready output.
// Optional feature: define MVM_SAT_EN to clamp results to OUT_WIDTH and flag clamping in tuser;
// without it results wrap and m_result_tuser is 0.
module mvm_stream_engine #(
   parameter int unsigned D_WIDTH   = 8,
   parameter int unsigned M_ROWS    = 2,
   parameter int unsigned N_COLS    = 3,
   parameter int unsigned OUT_WIDTH = 16
) (
   input  logic                                aclk,
   input  logic                                aresetn,
   input  logic                                s_matrix_tvalid,
   output logic                                s_matrix_tready,
   input  logic [D_WIDTH*M_ROWS*N_COLS-1:0]    s_matrix_tdata,
   input  logic                                s_vector_tvalid,
   output logic                                s_vector_tready,
   input  logic [D_WIDTH*N_COLS-1:0]           s_vector_tdata,
   output logic                                m_result_tvalid,
   input  logic                                m_result_tready,
   output logic [OUT_WIDTH*M_ROWS-1:0]         m_result_tdata,
   output logic [M_ROWS-1:0]                   m_result_tuser,
   output logic                                o_busy,
   output logic [15:0]                         o_result_count
);

   localparam int unsigned ACC_WIDTH = 2*D_WIDTH + $clog2(N_COLS) + 1;
   localparam int unsigned COL_W     = (N_COLS > 1) ? $clog2(N_COLS) : 1;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COLS - 1);

   typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

   state_e                       r_state;
   logic [COL_W-1:0]             r_col;
   logic signed [D_WIDTH-1:0]    r_a [M_ROWS][N_COLS];
   logic signed [D_WIDTH-1:0]    r_x [N_COLS];
   logic signed [ACC_WIDTH-1:0]  r_acc [M_ROWS];
   logic [OUT_WIDTH*M_ROWS-1:0]  r_tdata;
   logic [M_ROWS-1:0]            r_tuser;
   logic                         r_tvalid;
   logic                         r_busy;
   logic [15:0]                  r_count;

   logic                         w_accept;
   logic signed [2*D_WIDTH-1:0]  w_prod [M_ROWS];
   logic signed [ACC_WIDTH-1:0]  w_acc_next [M_ROWS];
   logic [OUT_WIDTH-1:0]         w_y [M_ROWS];
   logic [M_ROWS-1:0]            w_sat;
`ifdef MVM_SAT_EN
   logic [ACC_WIDTH-OUT_WIDTH:0] w_upper;
`endif

   // Joint accept: only when idle and both operands are offered; held off while in reset.
   assign w_accept        = aresetn && (r_state == StIdle) && s_matrix_tvalid && s_vector_tvalid;
   assign s_matrix_tready = w_accept;
   assign s_vector_tready = w_accept;

   assign m_result_tvalid = r_tvalid;
   assign m_result_tdata  = r_tdata;
   assign m_result_tuser  = r_tuser;
   assign o_busy          = r_busy;
   assign o_result_count  = r_count;

   // Per-row MAC for the current column and narrowing of the would-be final accumulator.
   always_comb begin
      w_sat = '0;
`ifdef MVM_SAT_EN
      w_upper = '0;
`endif
      for (int r = 0; r < M_ROWS; r++) begin
         w_prod[r]     = r_a[r][r_col] * r_x[r_col];
         w_acc_next[r] = r_acc[r]
                         + {{(ACC_WIDTH-2*D_WIDTH){w_prod[r][2*D_WIDTH-1]}}, w_prod[r]};
`ifdef MVM_SAT_EN
         // Bits above the output sign bit must all match the sign, otherwise clamp.
         w_upper = w_acc_next[r][ACC_WIDTH-1:OUT_WIDTH-1];
         if (!(&w_upper) && (|w_upper)) begin
            w_sat[r] = 1'b1;
            w_y[r]   = w_acc_next[r][ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                                  : {1'b0, {(OUT_WIDTH-1){1'b1}}};
         end else begin
            w_y[r] = w_acc_next[r][OUT_WIDTH-1:0];
         end
`else
         w_y[r] = w_acc_next[r][OUT_WIDTH-1:0];
`endif
      end
   end

   // Control FSM with registered outputs, operand capture and accumulation.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state  <= StIdle;
         r_col    <= '0;
         r_tdata  <= '0;
         r_tuser  <= '0;
         r_tvalid <= 1'b0;
         r_busy   <= 1'b0;
         r_count  <= '0;
         for (int r = 0; r < M_ROWS; r++) begin
            r_acc[r] <= '0;
            for (int c = 0; c < N_COLS; c++) r_a[r][c] <= '0;
         end
         for (int c = 0; c < N_COLS; c++) r_x[c] <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  for (int r = 0; r < M_ROWS; r++) begin
                     r_acc[r] <= '0;
                     for (int c = 0; c < N_COLS; c++)
                        r_a[r][c] <= s_matrix_tdata[(r*N_COLS+c)*D_WIDTH +: D_WIDTH];
                  end
                  for (int c = 0; c < N_COLS; c++)
                     r_x[c] <= s_vector_tdata[c*D_WIDTH +: D_WIDTH];
                  r_col   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= StMac;
               end
            end
            StMac: begin
               for (int r = 0; r < M_ROWS; r++) r_acc[r] <= w_acc_next[r];
               if (r_col == LAST_COL) begin
                  // Final column: register the narrowed result directly from the last sum.
                  for (int r = 0; r < M_ROWS; r++) r_tdata[r*OUT_WIDTH +: OUT_WIDTH] <= w_y[r];
                  r_tuser  <= w_sat;
                  r_tvalid <= 1'b1;
                  r_state  <= StOut;
               end else begin
                  r_col <= r_col + COL_W'(1);
               end
            end
            StOut: begin
               if (m_result_tready) begin
                  r_tvalid <= 1'b0;
                  r_busy   <= 1'b0;
                  r_count  <= r_count + 16'd1;
                  r_state  <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mvm_stream_engine.sv
// Directed testbench for mvm_stream_engine (M_ROWS=2, N_COLS=3, D_WIDTH=8, OUT_WIDTH=16).
// Expected results follow MVM_SAT_EN when the same macro is defined for the bench.
module tb_mvm_stream_engine;

   logic        aclk;
   logic        aresetn;
   logic        s_matrix_tvalid;
   logic        s_matrix_tready;
   logic [47:0] s_matrix_tdata;
   logic        s_vector_tvalid;
   logic        s_vector_tready;
   logic [23:0] s_vector_tdata;
   logic        m_result_tvalid;
   logic        m_result_tready;
   logic [31:0] m_result_tdata;
   logic [1:0]  m_result_tuser;
   logic        o_busy;
   logic [15:0] o_result_count;

   int n_total = 0;
   int n_bad   = 0;
   int exp_count = 0;

   mvm_stream_engine #(
      .D_WIDTH  (8),
      .M_ROWS   (2),
      .N_COLS   (3),
      .OUT_WIDTH(16)
   ) u_dut (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .s_matrix_tvalid(s_matrix_tvalid),
      .s_matrix_tready(s_matrix_tready),
      .s_matrix_tdata (s_matrix_tdata),
      .s_vector_tvalid(s_vector_tvalid),
      .s_vector_tready(s_vector_tready),
      .s_vector_tdata (s_vector_tdata),
      .m_result_tvalid(m_result_tvalid),
      .m_result_tready(m_result_tready),
      .m_result_tdata (m_result_tdata),
      .m_result_tuser (m_result_tuser),
      .o_busy         (o_busy),
      .o_result_count (o_result_count)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #2;
   endtask

   function automatic logic [47:0] mat(input int a00, a01, a02, a10, a11, a12);
      logic [7:0] e [6];
      e[0] = 8'(a00); e[1] = 8'(a01); e[2] = 8'(a02);
      e[3] = 8'(a10); e[4] = 8'(a11); e[5] = 8'(a12);
      return {e[5], e[4], e[3], e[2], e[1], e[0]};
   endfunction

   function automatic logic [23:0] vec(input int x0, x1, x2);
      logic [7:0] e0, e1, e2;
      e0 = 8'(x0); e1 = 8'(x1); e2 = 8'(x2);
      return {e2, e1, e0};
   endfunction

   // Offer both operands, check accept, latency, MAC-phase backpressure, result and handshake.
   task automatic do_op(input string tag, input logic [47:0] m, input logic [23:0] v,
                        input logic [31:0] ed, input logic [1:0] eu);
      s_matrix_tdata  = m;
      s_vector_tdata  = v;
      s_matrix_tvalid = 1'b1;
      s_vector_tvalid = 1'b1;
      #1;
      chk({tag, ".accept"}, {s_matrix_tready, s_vector_tready}, 2'b11);
      tick();
      for (int i = 0; i < 3; i++) begin
         chk({tag, ".mac_rdy"}, {s_matrix_tready, s_vector_tready}, 2'b00);
         chk({tag, ".mac_vld"}, m_result_tvalid, 1'b0);
         chk({tag, ".mac_busy"}, o_busy, 1'b1);
         if (i < 2) tick();
      end
      s_matrix_tvalid = 1'b0;
      s_vector_tvalid = 1'b0;
      tick();
      chk({tag, ".vld"}, m_result_tvalid, 1'b1);
      chk({tag, ".data"}, m_result_tdata, ed);
      chk({tag, ".user"}, m_result_tuser, eu);
      m_result_tready = 1'b1;
      tick();
      m_result_tready = 1'b0;
      exp_count++;
      chk({tag, ".vld_drop"}, m_result_tvalid, 1'b0);
      chk({tag, ".count"}, o_result_count, 16'(exp_count));
      chk({tag, ".idle"}, o_busy, 1'b0);
   endtask

   initial begin
      aresetn         = 1'b0;
      s_matrix_tvalid = 1'b1;
      s_vector_tvalid = 1'b1;
      s_matrix_tdata  = '0;
      s_vector_tdata  = '0;
      m_result_tready = 1'b0;
      #1;
      chk("rst.rdy", {s_matrix_tready, s_vector_tready}, 2'b00);
      chk("rst.out", {m_result_tvalid, m_result_tdata, m_result_tuser, o_busy, o_result_count},
          '0);
      s_matrix_tvalid = 1'b0;
      s_vector_tvalid = 1'b0;
      tick();
      tick();
      aresetn = 1'b1;
      tick();

      // Basic product and latency.
      do_op("t1", mat(1, 2, 3, 4, 5, 6), vec(1, 1, 1), 32'h000F_0006, 2'b00);

      // Sign extension: [-7, 128].
      do_op("t2", mat(-1, 2, -3, 0, -128, 0), vec(2, -1, 1), 32'h0080_FFF9, 2'b00);

      // Positive overflow of the output width: acc = 48387.
`ifdef MVM_SAT_EN
      do_op("t3", mat(127, 127, 127, 127, 127, 127), vec(127, 127, 127), 32'h7FFF_7FFF, 2'b11);
      do_op("t3n", mat(-128, -128, -128, 0, 0, 0), vec(127, 127, 127), 32'h0000_8000, 2'b01);
`else
      do_op("t3", mat(127, 127, 127, 127, 127, 127), vec(127, 127, 127), 32'hBD03_BD03, 2'b00);
      do_op("t3n", mat(-128, -128, -128, 0, 0, 0), vec(127, 127, 127), 32'h0000_4180, 2'b00);
`endif

      // Output backpressure: result held, inputs stalled, next accept only after handshake.
      s_matrix_tdata  = mat(1, 2, 3, 4, 5, 6);
      s_vector_tdata  = vec(2, 0, -1);
      s_matrix_tvalid = 1'b1;
      s_vector_tvalid = 1'b1;
      #1;
      chk("t4.accept", {s_matrix_tready, s_vector_tready}, 2'b11);
      tick();
      s_matrix_tdata = mat(1, 1, 1, 1, 1, 1);
      s_vector_tdata = vec(1, 2, 3);
      repeat (3) tick();
      for (int i = 0; i < 6; i++) begin
         chk("t4.hold_vld", m_result_tvalid, 1'b1);
         chk("t4.hold_data", m_result_tdata, 32'h0002_FFFF);
         chk("t4.hold_rdy", {s_matrix_tready, s_vector_tready}, 2'b00);
         if (i == 5) m_result_tready = 1'b1;
         tick();
      end
      m_result_tready = 1'b0;
      exp_count++;
      chk("t4.vld_drop", m_result_tvalid, 1'b0);
      chk("t4.count", o_result_count, 16'(exp_count));
      chk("t4.next_rdy", {s_matrix_tready, s_vector_tready}, 2'b11);
      do_op("t4b", mat(1, 1, 1, 1, 1, 1), vec(1, 2, 3), 32'h0006_0006, 2'b00);

      // Lone vector valid is never accepted; tready on an empty output is ignored.
      s_vector_tdata  = vec(4, 3, -6);
      s_vector_tvalid = 1'b1;
      m_result_tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t5.lone_rdy", {s_matrix_tready, s_vector_tready}, 2'b00);
         chk("t5.lone_busy", o_busy, 1'b0);
         tick();
      end
      m_result_tready = 1'b0;
      chk("t5.count", o_result_count, 16'(exp_count));
      do_op("t5", mat(3, -2, 1, -5, 7, 2), vec(4, 3, -6), 32'hFFF5_0000, 2'b00);

      // Reset during the second MAC cycle discards the operation.
      s_matrix_tdata  = mat(1, 2, 3, 4, 5, 6);
      s_vector_tdata  = vec(1, 1, 1);
      s_matrix_tvalid = 1'b1;
      s_vector_tvalid = 1'b1;
      #1;
      chk("t6.accept", {s_matrix_tready, s_vector_tready}, 2'b11);
      tick();
      s_matrix_tvalid = 1'b0;
      s_vector_tvalid = 1'b0;
      tick();
      aresetn = 1'b0;
      #1;
      chk("t6.rst_out", {m_result_tvalid, m_result_tdata, m_result_tuser, o_busy, o_result_count},
          '0);
      tick();
      aresetn = 1'b1;
      exp_count = 0;
      m_result_tready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t6.no_result", m_result_tvalid, 1'b0);
      end
      m_result_tready = 1'b0;
      chk("t6.count", o_result_count, 16'd0);
      do_op("t6b", mat(1, 2, 3, 4, 5, 6), vec(1, 1, 1), 32'h000F_0006, 2'b00);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
